// File: rtl/rp_pio_pkg.sv
// Shared PIO request/completion encodings and the exception register bit map.
package rp_pio_pkg;

    typedef enum logic [1:0] {
        REQ_CFG = 2'd0,
        REQ_IO  = 2'd1,
        REQ_MEM = 2'd2
    } req_type_e;

    typedef enum logic [2:0] {
        CPL_SC  = 3'b000,
        CPL_UR  = 3'b001,
        CPL_CRS = 3'b010,
        CPL_CA  = 3'b100
    } cpl_status_e;

    localparam int EXC_CFG_UR  = 0;
    localparam int EXC_CFG_CA  = 1;
    localparam int EXC_CFG_CTO = 2;
    localparam int EXC_IO_UR   = 8;
    localparam int EXC_IO_CA   = 9;
    localparam int EXC_IO_CTO  = 10;
    localparam int EXC_MEM_UR  = 16;
    localparam int EXC_MEM_CA  = 17;
    localparam int EXC_MEM_CTO = 18;

    // Offsets of UR/CA/CTO within one request type's byte lane
    localparam int EXC_UR_OFS  = 0;
    localparam int EXC_CA_OFS  = 1;
    localparam int EXC_CTO_OFS = 2;

    function automatic logic [31:0] exc_bit(input logic [1:0] t, input int ofs);
        int base;
        base = (t == REQ_IO)  ? EXC_IO_UR  :
               (t == REQ_MEM) ? EXC_MEM_UR : EXC_CFG_UR;
        return 32'd1 << (base + ofs);
    endfunction

endpackage

// File: rtl/rp_pio_tag_slot.sv
// One tracked tag: FREE/PENDING flag, latched request type and completion timer.
module rp_pio_tag_slot #(
    parameter int CTO_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_alloc,
    input  logic [1:0] i_type,
    input  logic       i_cpl,
    output logic       o_pending,
    output logic [1:0] o_type,
    output logic       o_timeout
);
    import rp_pio_pkg::*;

    localparam int TW = $clog2(CTO_CYCLES);

    logic          r_pending;
    logic [1:0]    r_type;
    logic [TW-1:0] r_timer;

    assign o_pending = r_pending;
    assign o_type    = r_type;
    assign o_timeout = r_pending && (r_timer == TW'(CTO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_type    <= 2'd0;
            r_timer   <= '0;
        end else if (r_pending) begin
            // A completion and a timeout both just release the slot here;
            // which one gets reported is decided by the top.
            if (i_cpl || o_timeout) begin
                r_pending <= 1'b0;
                r_timer   <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end else if (i_alloc) begin
            r_pending <= 1'b1;
            r_type    <= i_type;
            r_timer   <= '0;
        end
    end

endmodule

// File: rtl/rp_pio_cpl_tracker.sv
// Root-port PIO completion tracker: tag allocation, completion matching and timeout reporting.
module rp_pio_cpl_tracker #(
    parameter int NUM_TAGS   = 4,
    parameter int CTO_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    input  logic [1:0]                  req_type,
    output logic                        req_ready,
    output logic [$clog2(NUM_TAGS)-1:0] req_tag,
    input  logic                        cpl_valid,
    input  logic [$clog2(NUM_TAGS)-1:0] cpl_tag,
    input  logic [2:0]                  cpl_status,
    output logic [31:0]                 exc_set,
    output logic                        unexp_cpl,
    output logic [$clog2(NUM_TAGS):0]   outstanding
);
    import rp_pio_pkg::*;

    localparam int TAGW = $clog2(NUM_TAGS);
    localparam int CNTW = TAGW + 1;

    logic [NUM_TAGS-1:0]      w_pending;
    logic [NUM_TAGS-1:0][1:0] w_type;
    logic [NUM_TAGS-1:0]      w_timeout;
    logic [NUM_TAGS-1:0]      w_alloc;
    logic [NUM_TAGS-1:0]      w_cpl_hit;
    logic [TAGW-1:0]          w_free_tag;
    logic                     w_any_free;
    logic                     w_alloc_ok;
    logic [31:0]              w_exc_nxt;
    logic                     w_unexp_nxt;
    logic [CNTW-1:0]          w_count;
    logic [31:0]              r_exc_set;
    logic                     r_unexp_cpl;

    // Priority pick of the lowest FREE tag from registered state only
    always_comb begin
        w_free_tag = '0;
        w_any_free = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!w_pending[i]) begin
                w_free_tag = TAGW'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign req_ready  = w_any_free;
    assign req_tag    = w_free_tag;
    assign w_alloc_ok = req_valid && w_any_free && (req_type != 2'd3);

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_slot
        assign w_alloc[g]   = w_alloc_ok && (w_free_tag == TAGW'(g));
        assign w_cpl_hit[g] = cpl_valid && (cpl_tag == TAGW'(g));

        rp_pio_tag_slot #(.CTO_CYCLES(CTO_CYCLES)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_alloc   (w_alloc[g]),
            .i_type    (req_type),
            .i_cpl     (w_cpl_hit[g]),
            .o_pending (w_pending[g]),
            .o_type    (w_type[g]),
            .o_timeout (w_timeout[g])
        );
    end

    always_comb begin
        w_exc_nxt = '0;
        w_count   = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_count = w_count + CNTW'(w_pending[i]);
            if (w_pending[i]) begin
                if (w_cpl_hit[i]) begin
                    case (cpl_status)
                        CPL_SC:  ;
                        CPL_CA:  w_exc_nxt = w_exc_nxt | exc_bit(w_type[i], EXC_CA_OFS);
                        default: w_exc_nxt = w_exc_nxt | exc_bit(w_type[i], EXC_UR_OFS);
                    endcase
                end else if (w_timeout[i]) begin
                    w_exc_nxt = w_exc_nxt | exc_bit(w_type[i], EXC_CTO_OFS);
                end
            end
        end
    end

    assign w_unexp_nxt = cpl_valid && !w_pending[cpl_tag];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_set   <= '0;
            r_unexp_cpl <= 1'b0;
        end else begin
            r_exc_set   <= w_exc_nxt;
            r_unexp_cpl <= w_unexp_nxt;
        end
    end

    assign exc_set     = r_exc_set;
    assign unexp_cpl   = r_unexp_cpl;
    assign outstanding = w_count;

endmodule

// File: tb/tb_rp_pio_cpl_tracker.sv
// Scoreboard bench for rp_pio_cpl_tracker: expected exception pulses are queued with their cycle.
module tb_rp_pio_cpl_tracker;

    localparam int NT  = 4;
    localparam int CTO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_type = 2'd0;
    logic        req_ready;
    logic [1:0]  req_tag;
    logic        cpl_valid = 1'b0;
    logic [1:0]  cpl_tag = 2'd0;
    logic [2:0]  cpl_status = 3'd0;
    logic [31:0] exc_set;
    logic        unexp_cpl;
    logic [2:0]  outstanding;

    typedef struct {
        logic [31:0] exc;
        logic        unexp;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    rp_pio_cpl_tracker #(.NUM_TAGS(NT), .CTO_CYCLES(CTO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_type(req_type), .req_ready(req_ready), .req_tag(req_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_status(cpl_status),
        .exc_set(exc_set), .unexp_cpl(unexp_cpl), .outstanding(outstanding)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every nonzero output pulse with the cycle it was visible in
    always @(negedge clk) begin
        if (rst_n && (exc_set != 32'd0 || unexp_cpl)) begin
            ev_t o;
            o.exc = exc_set; o.unexp = unexp_cpl; o.cyc = cyc;
            obs_q.push_back(o);
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_ev(input logic [31:0] exc, input logic unexp, input int at);
        ev_t e;
        e.exc = exc; e.unexp = unexp; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (req_tag !== 2'd0) begin n_err++; $display("FAIL reset_tag: got %0d want 0", req_tag); end
        n_cmp++; if (exc_set !== 32'd0 || unexp_cpl !== 1'b0) begin n_err++; $display("FAIL reset_pulses: exc=%h unexp=%b want 0/0", exc_set, unexp_cpl); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_mem_sc;
        req_valid = 1'b1; req_type = 2'd2;
        n_cmp++; if (req_tag !== 2'd0) begin n_err++; $display("FAIL mem_tag: got %0d want 0", req_tag); end
        step(1);
        req_valid = 1'b0;
        n_cmp++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL mem_outstanding: got %0d want 1", outstanding); end
        cpl_valid = 1'b1; cpl_tag = 2'd0; cpl_status = 3'b000;
        step(1);
        cpl_valid = 1'b0;
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL mem_sc_outstanding: got %0d want 0", outstanding); end
        step(2);
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL mem_sc_missing: want exc=%h unexp=%b at %0d", e.exc, e.unexp, e.cyc); end
            else begin
                ev_t o = obs_q.pop_front();
                if (o.exc !== e.exc || o.unexp !== e.unexp || o.cyc != e.cyc) begin n_err++; $display("FAIL mem_sc_event: got %h/%b@%0d want %h/%b@%0d", o.exc, o.unexp, o.cyc, e.exc, e.unexp, e.cyc); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL mem_sc_spurious: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_cto;
        expect_ev(32'h0000_0004, 1'b0, cyc + 1 + CTO);
        req_valid = 1'b1; req_type = 2'd0;
        step(1);
        req_valid = 1'b0;
        step(CTO + 3);
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL cto_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if (req_tag !== 2'd0 || req_ready !== 1'b1) begin n_err++; $display("FAIL cto_free: tag=%0d ready=%b want 0/1", req_tag, req_ready); end
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL cto_missing: want exc=%h at %0d", e.exc, e.cyc); end
            else begin
                ev_t o = obs_q.pop_front();
                if (o.exc !== e.exc || o.unexp !== e.unexp || o.cyc != e.cyc) begin n_err++; $display("FAIL cto_event: got %h/%b@%0d want %h/%b@%0d", o.exc, o.unexp, o.cyc, e.exc, e.unexp, e.cyc); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL cto_spurious: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_status_merge;
        logic [1:0]  t_type [6] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
        logic [2:0]  t_stat [6] = '{3'b001, 3'b100, 3'b010, 3'b111, 3'b100, 3'b000};
        logic [31:0] t_exc  [6] = '{32'h100, 32'h20000, 32'h10000, 32'h1, 32'h2, 32'h0};
        int c0;
        for (int k = 0; k < 6; k++) begin
            req_valid = 1'b1; req_type = t_type[k];
            step(1);
            req_valid = 1'b0;
            cpl_valid = 1'b1; cpl_tag = 2'd0; cpl_status = t_stat[k];
            if (t_exc[k] != 32'd0) expect_ev(t_exc[k], 1'b0, cyc + 1);
            step(1);
            cpl_valid = 1'b0;
        end
        // IO tag 0 times out on the same edge that MEM tag 1 completes with CA
        c0 = cyc;
        req_valid = 1'b1; req_type = 2'd1;
        n_cmp++; if (req_tag !== 2'd0) begin n_err++; $display("FAIL merge_tag0: got %0d want 0", req_tag); end
        step(1);
        req_type = 2'd2;
        n_cmp++; if (req_tag !== 2'd1) begin n_err++; $display("FAIL merge_tag1: got %0d want 1", req_tag); end
        step(1);
        req_valid = 1'b0;
        step(CTO - 2);
        cpl_valid = 1'b1; cpl_tag = 2'd1; cpl_status = 3'b100;
        expect_ev(32'h0002_0400, 1'b0, c0 + 1 + CTO);
        step(1);
        cpl_valid = 1'b0;
        step(3);
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL merge_outstanding: got %0d want 0", outstanding); end
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL status_missing: want exc=%h at %0d", e.exc, e.cyc); end
            else begin
                ev_t o = obs_q.pop_front();
                if (o.exc !== e.exc || o.unexp !== e.unexp || o.cyc != e.cyc) begin n_err++; $display("FAIL status_event: got %h/%b@%0d want %h/%b@%0d", o.exc, o.unexp, o.cyc, e.exc, e.unexp, e.cyc); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL status_spurious: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_full;
        logic [1:0] types [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_type = types[k];
            n_cmp++; if (req_tag !== 2'(k)) begin n_err++; $display("FAIL fill_tag%0d: got %0d want %0d", k, req_tag, k); end
            step(1);
        end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", req_ready); end
        req_type = 2'd0;
        step(1);
        req_valid = 1'b0;
        n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_outstanding: got %0d want 4", outstanding); end
        cpl_valid = 1'b1; cpl_tag = 2'd2; cpl_status = 3'b000;
        step(1);
        cpl_valid = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || req_tag !== 2'd2) begin n_err++; $display("FAIL refill: ready=%b tag=%0d want 1/2", req_ready, req_tag); end
        req_valid = 1'b1; req_type = 2'd3;
        step(1);
        req_valid = 1'b0;
        n_cmp++; if (outstanding !== 3'd3 || req_tag !== 2'd2) begin n_err++; $display("FAIL rsvd_type: outstanding=%0d tag=%0d want 3/2", outstanding, req_tag); end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) continue;
            cpl_valid = 1'b1; cpl_tag = 2'(k); cpl_status = 3'b000;
            step(1);
        end
        cpl_valid = 1'b0;
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL drain_outstanding: got %0d want 0", outstanding); end
        step(2);
        n_cmp++; if (obs_q.size() != 0 || exp_q.size() != 0) begin n_err++; $display("FAIL full_spurious: got %0d events want 0", obs_q.size()); obs_q.delete(); exp_q.delete(); end
    endtask

    task automatic test_unexp_race;
        int c0;
        cpl_valid = 1'b1; cpl_tag = 2'd3; cpl_status = 3'b100;
        expect_ev(32'h0, 1'b1, cyc + 1);
        step(1);
        cpl_valid = 1'b0;
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL unexp_state: got %0d want 0", outstanding); end
        // Completion lands on the cycle the timer sits at its limit
        c0 = cyc;
        req_valid = 1'b1; req_type = 2'd0;
        step(1);
        req_valid = 1'b0;
        step(CTO - 1);
        cpl_valid = 1'b1; cpl_tag = 2'd0; cpl_status = 3'b001;
        expect_ev(32'h0000_0001, 1'b0, c0 + CTO + 1);
        step(1);
        cpl_valid = 1'b0;
        step(CTO + 2);
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL race_outstanding: got %0d want 0", outstanding); end
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL unexp_missing: want exc=%h unexp=%b at %0d", e.exc, e.unexp, e.cyc); end
            else begin
                ev_t o = obs_q.pop_front();
                if (o.exc !== e.exc || o.unexp !== e.unexp || o.cyc != e.cyc) begin n_err++; $display("FAIL unexp_event: got %h/%b@%0d want %h/%b@%0d", o.exc, o.unexp, o.cyc, e.exc, e.unexp, e.cyc); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL unexp_spurious: got %0d extra events want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_inflight;
        logic [1:0] types [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_type = types[k];
            step(1);
        end
        req_valid = 1'b0;
        cpl_valid = 1'b1; cpl_tag = 2'd0; cpl_status = 3'b001;
        step(1);
        cpl_valid = 1'b0;
        n_cmp++; if (outstanding !== 3'd3 || exc_set !== 32'h1) begin n_err++; $display("FAIL pre_reset: outstanding=%0d exc=%h want 3/00000001", outstanding, exc_set); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (outstanding !== 3'd0 || req_ready !== 1'b1 || req_tag !== 2'd0) begin n_err++; $display("FAIL async_reset: outstanding=%0d ready=%b tag=%0d want 0/1/0", outstanding, req_ready, req_tag); end
        n_cmp++; if (exc_set !== 32'd0 || unexp_cpl !== 1'b0) begin n_err++; $display("FAIL async_reset_pulses: exc=%h unexp=%b want 0/0", exc_set, unexp_cpl); end
        step(1);
        rst_n = 1'b1;
        step(2 * CTO + 4);
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL post_reset_events: got %0d events want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_mem_sc();
        test_cto();
        test_status_merge();
        test_full();
        test_unexp_race();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
